source_frame_sched: RTL and testbench

SOURCE_FRAME_SCHED -- requirements
Module: source_frame_sched

---
 rtl/source_frame_sched_pkg.sv | 17 +
 rtl/source_frame_sched_rise_edge_det.sv | 22 ++
 rtl/source_frame_sched.sv | 221 ++++++++++++++++++++++
 tb/tb_source_frame_sched.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/source_frame_sched_pkg.sv
// Shared types and constants for the frame scheduler.
// State encoding, header sync word and field widths.
package source_frame_sched_pkg;

    localparam int LEN_W = 16;
    localparam int CNT_W = 32;

    localparam logic [LEN_W-1:0] HEAD_SYNC = 16'hEB90;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HEAD  = 2'd1,
        ST_DATA  = 2'd2,
        ST_BLANK = 2'd3
    } state_t;

endpackage

// File: rtl/source_frame_sched_rise_edge_det.sv
// Rising-edge detector for a CPU level register.
// History resets low so a level already high at reset release is an edge.
module rise_edge_det (
    input  logic clk,
    input  logic i_rst,
    input  logic i_level,
    output logic o_rise
);

    logic r_prev;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= i_level;
        end
    end

    assign o_rise = i_level & ~r_prev;

endmodule

// File: rtl/source_frame_sched.sv
// Frame source scheduler: emits optional header, payload words and
// inter-frame blank gaps, with backpressure, stop and run-length control.
module source_frame_sched
    import source_frame_sched_pkg::*;
(
    input  logic             clk,
    input  logic             pRST,
    input  logic             start_send,
    input  logic             stop_send,
    input  logic [LEN_W-1:0] framelen,
    input  logic [LEN_W-1:0] blanklen,
    input  logic [CNT_W-1:0] totalnum,
    input  logic             headen,
    input  logic             fifo_full,
    output logic [CNT_W-1:0] dout,
    output logic             dout_valid,
    output logic             sof,
    output logic             eof,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] frame_cnt
);

    logic w_start_e;
    logic w_stop_e;

    rise_edge_det u_start_det (
        .clk     (clk),
        .i_rst   (pRST),
        .i_level (start_send),
        .o_rise  (w_start_e)
    );

    rise_edge_det u_stop_det (
        .clk     (clk),
        .i_rst   (pRST),
        .i_level (stop_send),
        .o_rise  (w_stop_e)
    );

    state_t           r_state;
    logic [LEN_W-1:0] r_idx;
    logic [LEN_W-1:0] r_bcnt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_stop_req;
    logic [LEN_W-1:0] r_flen;
    logic [LEN_W-1:0] r_blen;
    logic [CNT_W-1:0] r_total;
    logic             r_hen;
    logic [CNT_W-1:0] r_dout;
    logic             r_valid;
    logic             r_sof;
    logic             r_eof;
    logic             r_busy;
    logic             r_done;

    logic             w_start_go;
    logic [LEN_W-1:0] w_flen_in;
    logic [LEN_W-1:0] w_flen;
    logic [LEN_W-1:0] w_blen;
    logic [CNT_W-1:0] w_total;
    logic             w_hen;
    state_t           w_ph;
    state_t           w_frame_ph;
    logic [LEN_W-1:0] w_idx;
    logic [CNT_W-1:0] w_cnt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_stop;
    logic             w_last;

    // A run begins here; the first word goes out on this same edge.
    assign w_start_go = (r_state == ST_IDLE) & w_start_e & ~w_stop_e;
    assign w_flen_in  = (framelen == '0) ? LEN_W'(1) : framelen;

    assign w_flen  = w_start_go ? w_flen_in : r_flen;
    assign w_blen  = w_start_go ? blanklen  : r_blen;
    assign w_total = w_start_go ? totalnum  : r_total;
    assign w_hen   = w_start_go ? headen    : r_hen;

    assign w_frame_ph = w_hen ? ST_HEAD : ST_DATA;
    assign w_ph       = w_start_go ? w_frame_ph : r_state;
    assign w_idx      = w_start_go ? '0 : r_idx;
    assign w_cnt      = w_start_go ? '0 : r_cnt;
    assign w_stop     = ~w_start_go & (r_stop_req | w_stop_e);
    assign w_cnt_inc  = w_cnt + CNT_W'(1);
    assign w_last     = (w_idx == LEN_W'(w_flen - LEN_W'(1)));

    state_t           w_state_nxt;
    logic [LEN_W-1:0] w_idx_nxt;
    logic [LEN_W-1:0] w_bcnt_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_stop_nxt;
    logic [CNT_W-1:0] w_dout_nxt;
    logic             w_valid_nxt;
    logic             w_sof_nxt;
    logic             w_eof_nxt;
    logic             w_done_nxt;
    logic             w_busy_nxt;

    always_comb begin
        w_state_nxt = w_ph;
        w_idx_nxt   = w_idx;
        w_bcnt_nxt  = r_bcnt;
        w_cnt_nxt   = w_cnt;
        w_stop_nxt  = w_stop;
        w_dout_nxt  = r_dout;
        w_valid_nxt = 1'b0;
        w_sof_nxt   = 1'b0;
        w_eof_nxt   = 1'b0;
        w_done_nxt  = 1'b0;

        unique case (w_ph)
            ST_IDLE: begin
                w_stop_nxt = 1'b0;
            end
            ST_HEAD: begin
                if (!fifo_full) begin
                    w_valid_nxt = 1'b1;
                    w_sof_nxt   = 1'b1;
                    w_dout_nxt  = {HEAD_SYNC, w_cnt[LEN_W-1:0]};
                    w_state_nxt = ST_DATA;
                    w_idx_nxt   = '0;
                end
            end
            ST_DATA: begin
                if (!fifo_full) begin
                    w_valid_nxt = 1'b1;
                    w_sof_nxt   = (w_idx == '0) & ~w_hen;
                    w_dout_nxt  = {w_cnt[LEN_W-1:0], w_idx};
                    if (w_last) begin
                        w_eof_nxt  = 1'b1;
                        w_cnt_nxt  = w_cnt_inc;
                        w_idx_nxt  = '0;
                        w_bcnt_nxt = '0;
                        w_stop_nxt = 1'b0;
                        // A pending stop wins over run completion: no done.
                        if (w_stop) begin
                            w_state_nxt = ST_IDLE;
                        end else if ((w_total != '0) &&
                                     (w_cnt_inc == w_total)) begin
                            w_state_nxt = ST_IDLE;
                            w_done_nxt  = 1'b1;
                        end else if (w_blen != '0) begin
                            w_state_nxt = ST_BLANK;
                        end else begin
                            w_state_nxt = w_frame_ph;
                        end
                    end else begin
                        w_idx_nxt = LEN_W'(w_idx + LEN_W'(1));
                    end
                end
            end
            ST_BLANK: begin
                if (w_stop) begin
                    w_state_nxt = ST_IDLE;
                    w_stop_nxt  = 1'b0;
                    w_bcnt_nxt  = '0;
                end else if (!fifo_full) begin
                    if (LEN_W'(r_bcnt + LEN_W'(1)) == w_blen) begin
                        w_state_nxt = w_frame_ph;
                        w_bcnt_nxt  = '0;
                    end else begin
                        w_bcnt_nxt = LEN_W'(r_bcnt + LEN_W'(1));
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != ST_IDLE) | w_valid_nxt;
    end

    always_ff @(posedge clk) begin
        if (pRST) begin
            r_state    <= ST_IDLE;
            r_idx      <= '0;
            r_bcnt     <= '0;
            r_cnt      <= '0;
            r_stop_req <= 1'b0;
            r_flen     <= '0;
            r_blen     <= '0;
            r_total    <= '0;
            r_hen      <= 1'b0;
            r_dout     <= '0;
            r_valid    <= 1'b0;
            r_sof      <= 1'b0;
            r_eof      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_bcnt     <= w_bcnt_nxt;
            r_cnt      <= w_cnt_nxt;
            r_stop_req <= w_stop_nxt;
            r_dout     <= w_dout_nxt;
            r_valid    <= w_valid_nxt;
            r_sof      <= w_sof_nxt;
            r_eof      <= w_eof_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            if (w_start_go) begin
                r_flen  <= w_flen_in;
                r_blen  <= blanklen;
                r_total <= totalnum;
                r_hen   <= headen;
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_valid;
    assign sof        = r_sof;
    assign eof        = r_eof;
    assign busy       = r_busy;
    assign done       = r_done;
    assign frame_cnt  = r_cnt;

endmodule

// File: tb/tb_source_frame_sched.sv
// Directed self-checking bench for source_frame_sched.
// Observed bundle: {valid, sof, eof, done, busy, dout (0 when not valid)}.
module tb_source_frame_sched;

    logic        clk = 1'b0;
    logic        pRST;
    logic        start_send;
    logic        stop_send;
    logic [15:0] framelen;
    logic [15:0] blanklen;
    logic [31:0] totalnum;
    logic        headen;
    logic        fifo_full;
    logic [31:0] dout;
    logic        dout_valid;
    logic        sof;
    logic        eof;
    logic        busy;
    logic        done;
    logic [31:0] frame_cnt;

    int errors = 0;
    int checks = 0;

    source_frame_sched dut (
        .clk        (clk),
        .pRST       (pRST),
        .start_send (start_send),
        .stop_send  (stop_send),
        .framelen   (framelen),
        .blanklen   (blanklen),
        .totalnum   (totalnum),
        .headen     (headen),
        .fifo_full  (fifo_full),
        .dout       (dout),
        .dout_valid (dout_valid),
        .sof        (sof),
        .eof        (eof),
        .busy       (busy),
        .done       (done),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [36:0] obs();
        return {dout_valid, sof, eof, done, busy,
                dout_valid ? dout : 32'h0};
    endfunction

    task automatic cfg(input logic [15:0] fl, input logic [15:0] bl,
                       input logic [31:0] tn, input logic he);
        framelen = fl;
        blanklen = bl;
        totalnum = tn;
        headen   = he;
    endtask

    task automatic test_reset();
        logic [36:0] exp;
        pRST = 1'b1;
        start_send = 1'b0;
        tick();
        tick();
        checks++;
        if (obs() !== 37'h0 || dout !== 32'h0 || frame_cnt !== 32'h0) begin
            errors++;
            $display("FAIL reset_vals: got %h dout=%h cnt=%h want 0",
                     obs(), dout, frame_cnt);
        end
        // start already high when reset releases counts as an edge
        cfg(16'd1, 16'd0, 32'd1, 1'b0);
        start_send = 1'b1;
        pRST = 1'b0;
        tick();
        exp = {5'b11111, 32'h0};
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL reset_release_edge: got %h want %h", obs(), exp);
        end
        start_send = 1'b0;
        tick();
    endtask

    task automatic test_head_blank();
        logic [36:0] exp;
        cfg(16'd4, 16'd2, 32'd2, 1'b1);
        start_send = 1'b1;
        tick();
        start_send = 1'b0;
        cfg(16'd7, 16'd0, 32'd9, 1'b0);
        for (int c = 0; c < 13; c++) begin
            if (c == 0) exp = {5'b11001, 32'hEB90_0000};
            else if (c <= 4)
                exp = {1'b1, 1'b0, c == 4, 2'b01, 32'h0000_0000 + 32'(c - 1)};
            else if (c <= 6) exp = {5'b00001, 32'h0};
            else if (c == 7) exp = {5'b11001, 32'hEB90_0001};
            else if (c <= 11)
                exp = {1'b1, 1'b0, c == 11, c == 11, 1'b1,
                       32'h0001_0000 + 32'(c - 8)};
            else exp = {5'b00000, 32'h0};
            checks++;
            if (obs() !== exp) begin
                errors++;
                $display("FAIL head_blank c%0d: got %h want %h", c, obs(), exp);
            end
            tick();
        end
        checks++;
        if (frame_cnt !== 32'd2) begin
            errors++;
            $display("FAIL head_blank_cnt: got %0d want 2", frame_cnt);
        end
    endtask

    task automatic test_backpressure();
        logic [36:0] exp;
        cfg(16'd3, 16'd0, 32'd1, 1'b0);
        start_send = 1'b1;
        tick();
        start_send = 1'b0;
        fifo_full = 1'b1;
        for (int c = 0; c < 9; c++) begin
            if (c == 0) exp = {5'b11001, 32'h0};
            else if (c <= 5) exp = {5'b00001, 32'h0};
            else if (c == 6) exp = {5'b10001, 32'h0000_0001};
            else if (c == 7) exp = {5'b10111, 32'h0000_0002};
            else exp = {5'b00000, 32'h0};
            checks++;
            if (obs() !== exp) begin
                errors++;
                $display("FAIL stall c%0d: got %h want %h", c, obs(), exp);
            end
            if (c == 5) fifo_full = 1'b0;
            tick();
        end
        checks++;
        if (frame_cnt !== 32'd1) begin
            errors++;
            $display("FAIL stall_cnt: got %0d want 1", frame_cnt);
        end
    endtask

    task automatic test_stop_unlimited();
        logic [36:0] exp;
        cfg(16'd2, 16'd0, 32'd0, 1'b0);
        start_send = 1'b1;
        tick();
        start_send = 1'b0;
        for (int c = 0; c < 13; c++) begin
            if (c == 12) exp = {5'b00000, 32'h0};
            else if (c % 2 == 0)
                exp = {5'b11001, 16'(c / 2), 16'h0000};
            else
                exp = {5'b10101, 16'(c / 2), 16'h0001};
            checks++;
            if (obs() !== exp) begin
                errors++;
                $display("FAIL stop_run c%0d: got %h want %h", c, obs(), exp);
            end
            if (c == 10) stop_send = 1'b1;
            tick();
        end
        stop_send = 1'b0;
        checks++;
        if (frame_cnt !== 32'd6) begin
            errors++;
            $display("FAIL stop_cnt: got %0d want 6", frame_cnt);
        end
    endtask

    task automatic test_zero_len();
        logic [36:0] exp;
        cfg(16'd0, 16'd5, 32'd1, 1'b0);
        start_send = 1'b1;
        tick();
        start_send = 1'b0;
        exp = {5'b11111, 32'h0};
        checks++;
        if (obs() !== exp) begin
            errors++;
            $display("FAIL zero_len: got %h want %h", obs(), exp);
        end
        tick();
        checks++;
        if (obs() !== 37'h0 || frame_cnt !== 32'd1) begin
            errors++;
            $display("FAIL zero_len_end: got %h cnt=%0d want 0 cnt=1",
                     obs(), frame_cnt);
        end
    endtask

    task automatic test_stop_blank();
        cfg(16'd1, 16'd4, 32'd0, 1'b0);
        start_send = 1'b1;
        tick();
        start_send = 1'b0;
        checks++;
        if (obs() !== {5'b11101, 32'h0}) begin
            errors++;
            $display("FAIL stop_blank_w: got %h want %h", obs(),
                     {5'b11101, 32'h0});
        end
        tick();
        checks++;
        if (obs() !== {5'b00001, 32'h0}) begin
            errors++;
            $display("FAIL stop_blank_gap: got %h want %h", obs(),
                     {5'b00001, 32'h0});
        end
        stop_send = 1'b1;
        tick();
        stop_send = 1'b0;
        checks++;
        if (obs() !== 37'h0 || frame_cnt !== 32'd1) begin
            errors++;
            $display("FAIL stop_blank_idle: got %h cnt=%0d want 0 cnt=1",
                     obs(), frame_cnt);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [36:0] exp;
        cfg(16'd8, 16'd0, 32'd0, 1'b1);
        start_send = 1'b1;
        tick();
        start_send = 1'b0;
        tick();
        tick();
        checks++;
        if (obs() !== {5'b10001, 32'h0000_0001}) begin
            errors++;
            $display("FAIL mid_pre: got %h want %h", obs(),
                     {5'b10001, 32'h0000_0001});
        end
        pRST = 1'b1;
        tick();
        checks++;
        if (obs() !== 37'h0 || dout !== 32'h0 || frame_cnt !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset: got %h dout=%h cnt=%h want 0",
                     obs(), dout, frame_cnt);
        end
        pRST = 1'b0;
        tick();
        cfg(16'd1, 16'd0, 32'd1, 1'b0);
        start_send = 1'b1;
        tick();
        start_send = 1'b0;
        exp = {5'b11111, 32'h0};
        checks++;
        if (obs() !== exp || frame_cnt !== 32'd1) begin
            errors++;
            $display("FAIL mid_rerun: got %h cnt=%0d want %h cnt=1",
                     obs(), frame_cnt, exp);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [36:0] exp;
        start_send = 1'b1;
        stop_send = 1'b1;
        tick();
        checks++;
        if (obs() !== 37'h0) begin
            errors++;
            $display("FAIL start_stop: got %h want 0", obs());
        end
        tick();
        start_send = 1'b0;
        stop_send = 1'b0;
        tick();
        checks++;
        if (obs() !== 37'h0) begin
            errors++;
            $display("FAIL start_stop_hold: got %h want 0", obs());
        end
        cfg(16'd2, 16'd0, 32'd2, 1'b0);
        start_send = 1'b1;
        tick();
        for (int c = 0; c < 5; c++) begin
            case (c)
                0: exp = {5'b11001, 32'h0000_0000};
                1: exp = {5'b10101, 32'h0000_0001};
                2: exp = {5'b11001, 32'h0001_0000};
                3: exp = {5'b10111, 32'h0001_0001};
                default: exp = {5'b00000, 32'h0};
            endcase
            checks++;
            if (obs() !== exp) begin
                errors++;
                $display("FAIL busy_start c%0d: got %h want %h", c, obs(), exp);
            end
            start_send = (c == 1);
            tick();
        end
        start_send = 1'b0;
        checks++;
        if (frame_cnt !== 32'd2) begin
            errors++;
            $display("FAIL busy_start_cnt: got %0d want 2", frame_cnt);
        end
    endtask

    initial begin
        pRST = 1'b1;
        start_send = 1'b0;
        stop_send = 1'b0;
        fifo_full = 1'b0;
        cfg(16'd0, 16'd0, 32'd0, 1'b0);
        test_reset();
        test_head_blank();
        test_backpressure();
        test_stop_unlimited();
        test_zero_len();
        test_stop_blank();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
